// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side frame buffer placed behind UART_processor. Every completed
//   frame (one per frame_valid high period) is pushed into a circular FIFO so
//   the slower display/command logic can drain frames at its own pace.
//   Overflow is sticky and never hidden.
//
// Ports
//   clk_16bd      : sole clock (16x baud clock shared with UART_processor)
//   rst           : asynchronous, active-high reset
//   frame         : received frame, sampled on the rising edge of frame_valid
//   frame_valid   : frame qualifier, may stay high for several cycles
//   rd_en         : consumer read request, sampled each clock
//   clr_overflow  : synchronous clear of the sticky overflow flag
//   rd_data       : registered read data, holds last popped value
//   rd_valid      : one-cycle pulse when rd_data holds a newly popped entry
//   empty / full  : registered occupancy flags, aligned with count
//   count         : occupancy 0..DEPTH
//   overflow      : sticky, a frame arrived while full with no read
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_16bd,
  input  logic              rst,
  input  logic [DATA_W-1:0] frame,
  input  logic              frame_valid,
  input  logic              rd_en,
  input  logic              clr_overflow,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              fv_q;
  logic              wr_stb;
  logic              wr_ok;
  logic              rd_ok;
  logic [ADDR_W:0]   count_nxt;
  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

  // Next occupancy; full/empty are registered from this so they line up
  // with count in the same cycle.
  function automatic logic [ADDR_W:0] next_count(input logic [ADDR_W:0] cnt,
                                                 input logic wr,
                                                 input logic rd);
    logic [ADDR_W:0] res;
    res = cnt;
    if (wr && !rd)
      res = cnt + (ADDR_W+1)'(1);
    else if (rd && !wr)
      res = cnt - (ADDR_W+1)'(1);
    return res;
  endfunction

  // History resets to 1 so a frame_valid held across reset release is not
  // mistaken for a new frame.
  assign wr_stb    = frame_valid & ~fv_q;
  assign rd_ok     = rd_en & ~empty;
  // A read in the same cycle frees a slot, so a write into a full FIFO
  // is still accepted then.
  assign wr_ok     = wr_stb & (~full | rd_ok);
  assign count_nxt = next_count(count, wr_ok, rd_ok);

  // Storage: data only, not reset
  always_ff @(posedge clk_16bd) begin
    if (wr_ok)
      mem[wr_ptr] <= frame;
  end

  // Stage p1: pointer/occupancy control and registered read port
  always_ff @(posedge clk_16bd or posedge rst) begin
    if (rst) begin
      fv_q       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
      vld_p1     <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      fv_q   <= frame_valid;
      count  <= count_nxt;
      empty  <= (count_nxt == '0);
      full   <= (count_nxt == (ADDR_W+1)'(DEPTH));
      vld_p1 <= rd_ok;
      if (wr_ok)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_ok) begin
        rd_ptr     <= rd_ptr + ADDR_W'(1);
        rd_data_p1 <= mem[rd_ptr];
      end
      // Set has priority over clear.
      if (wr_stb && !wr_ok)
        overflow <= 1'b1;
      else if (clr_overflow)
        overflow <= 1'b0;
    end
  end

  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DATA_W = 9;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk_16bd = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] frame = '0;
  logic              frame_valid = 1'b1;
  logic              rd_en = 1'b0;
  logic              clr_overflow = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored frames plus expected output registers
  int q[$];
  int exp_data = 0;
  int exp_vld  = 0;
  int exp_ovf  = 0;
  int prev_fv  = 1;

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_16bd     (clk_16bd),
    .rst          (rst),
    .frame        (frame),
    .frame_valid  (frame_valid),
    .rd_en        (rd_en),
    .clr_overflow (clr_overflow),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk_16bd = ~clk_16bd;

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rd_valid"}, 32'(rd_valid), exp_vld);
    chk({tag, ".rd_data"},  32'(rd_data),  exp_data);
    chk({tag, ".count"},    32'(count),    q.size());
    chk({tag, ".empty"},    32'(empty),    (q.size() == 0) ? 1 : 0);
    chk({tag, ".full"},     32'(full),     (q.size() == DEPTH) ? 1 : 0);
    chk({tag, ".overflow"}, 32'(overflow), exp_ovf);
  endtask

  // One clock: inputs applied at negedge, model advanced at posedge,
  // outputs checked 1 time unit later. Returns at the next negedge.
  task automatic drive(input string tag, input int fv, input int f,
                       input int re, input int clr);
    int stb, rd, wr;
    frame_valid  = fv[0];
    frame        = f[DATA_W-1:0];
    rd_en        = re[0];
    clr_overflow = clr[0];
    @(posedge clk_16bd);
    stb = (fv != 0 && prev_fv == 0) ? 1 : 0;
    rd  = (re != 0 && q.size() > 0) ? 1 : 0;
    wr  = (stb != 0 && (q.size() < DEPTH || rd != 0)) ? 1 : 0;
    exp_vld = rd;
    if (rd != 0) exp_data = q.pop_front();
    if (wr != 0) q.push_back(f & ((1 << DATA_W) - 1));
    if (stb != 0 && wr == 0) exp_ovf = 1;
    else if (clr != 0) exp_ovf = 0;
    prev_fv = fv;
    #1;
    check_all(tag);
    @(negedge clk_16bd);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    q.delete();
    exp_data = 0;
    exp_vld  = 0;
    exp_ovf  = 0;
    prev_fv  = 1;
    check_all({tag, ".async"});
    repeat (2) @(posedge clk_16bd);
    #1;
    check_all({tag, ".held"});
    @(negedge clk_16bd);
    rst = 1'b0;
  endtask

  task automatic write_frame(input string tag, input int f);
    drive(tag, 1, f, 0, 0);
    drive(tag, 0, f, 0, 0);
  endtask

  initial begin
    // Reset with frame_valid held high: release must not write
    #2;
    frame_valid = 1'b1;
    do_reset("rst0");
    drive("rst_release", 1, 'h1AA, 0, 0);
    drive("rst_release", 1, 'h1AA, 0, 0);
    drive("rst_release", 0, 'h1AA, 0, 0);

    // Long frame_valid pulse writes once, then one read
    for (int i = 0; i < 5; i++) drive("long_fv", 1, 'h0A5, 0, 0);
    drive("long_fv_low", 0, 'h0A5, 0, 0);
    drive("read_a5", 0, 0, 1, 0);
    drive("after_a5", 0, 0, 0, 0);

    // Fill to full, drop a 17th frame
    for (int i = 0; i < DEPTH; i++) write_frame("fill", 'h100 + i);
    write_frame("drop_1ff", 'h1FF);
    drive("clr1", 0, 0, 0, 1);
    // Read while full coinciding with a new frame edge
    drive("full_rw", 1, 'h055, 1, 0);
    drive("full_rw_low", 0, 'h055, 0, 0);
    for (int i = 0; i < DEPTH; i++) drive("drain", 0, 0, 1, 0);
    drive("drain_idle", 0, 0, 1, 0);

    // Read on empty coinciding with a write: no fall-through
    drive("empty_rw", 1, 'h033, 1, 0);
    drive("read_33", 0, 0, 1, 0);
    drive("idle", 0, 0, 0, 0);

    // Pointer wrap with interleaved write/read pairs
    for (int i = 0; i < 40; i++) begin
      drive("wrap_wr", 1, 'h040 + i, 0, 0);
      drive("wrap_rd", 0, 0, 1, 0);
      chk("wrap_count_le1", 32'(count <= 1), 1);
    end

    // Overflow set vs clear priority
    for (int i = 0; i < DEPTH; i++) write_frame("fill2", 'h0C0 + i);
    write_frame("ovf_set", 'h111);
    drive("ovf_clr_same", 1, 'h122, 0, 1);
    drive("ovf_clr_alone", 0, 0, 0, 1);
    drive("ovf_idle", 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) drive("drain2", 0, 0, 1, 0);

    // Randomized traffic with one mid-operation reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        frame_valid = 1'b1;
        #2;
        do_reset("rst_mid");
      end
      drive("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 511)),
            ($urandom_range(0, 9) < ((i % 200) < 100 ? 3 : 7)) ? 1 : 0,
            ($urandom_range(0, 15) == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side frame buffer that sits directly downstream of UART_processor. It captures each completed frame (frame[8:0] qualified by frame_valid) into a circular FIFO, so the slower display/command logic can drain frames at its own pace. It runs in the receiver's clk_16bd domain and decouples frame arrival from frame consumption. Overflow is flagged, never silently hidden.

Parameters:
DATA_W, 9, width of a stored frame; matches UART_processor frame output
DEPTH, 16, number of FIFO entries; power of two, at least 2
ADDR_W, 4, pointer width; equals log2(DEPTH)

Ports:
clk_16bd  input  1  sole clock (16x baud clock shared with UART_processor)
rst  input  1  asynchronous, active-high reset
frame  input  DATA_W  received frame from UART_processor
frame_valid  input  1  frame qualifier from UART_processor; may stay high for several cycles
rd_en  input  1  consumer read request, sampled each clock
clr_overflow  input  1  synchronous clear of the sticky overflow flag
rd_data  output  DATA_W  registered read data
rd_valid  output  1  one-cycle pulse: rd_data holds a newly popped entry
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a frame arrived while the FIFO was full

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, empty=1, full=0, frame_valid history register=1. Storage array is not reset.
- Because the history register resets to 1, a frame_valid already high when reset releases does not generate a write.
- Write strobe: wr_stb = frame_valid & ~fv_q, with fv_q <= frame_valid every cycle. Each frame_valid high period writes exactly one entry, whatever its length. frame is sampled in the wr_stb cycle.
- Write accepted (wr_ok) when wr_stb and (~full or rd_ok). mem[wr_ptr] <= frame, then wr_ptr advances and wraps from DEPTH-1 to 0.
- Write while full with no simultaneous read: frame is dropped, pointers are unchanged, and overflow <= 1.
- Read accepted (rd_ok) when rd_en and ~empty. rd_data <= mem[rd_ptr] on the next edge, rd_valid=1 for that one cycle, and rd_ptr advances and wraps.
- Read latency is 1 clock from the rd_en sample to rd_valid.
- rd_en while empty is ignored: rd_valid=0 and rd_data holds its value. There is no fall-through, even if a write happens in the same cycle.
- Simultaneous wr_ok and rd_ok: both take effect and count is unchanged. This applies when full: the read frees the slot, so the write is accepted and no overflow is raised.
- count: +1 on wr_ok only, -1 on rd_ok only, unchanged otherwise.
- empty and full are registered, derived from the next-state count, and valid in the same cycle as count.
- overflow stays at 1 until clr_overflow. If a new overflow and clr_overflow occur in the same cycle, set wins.
- rd_data holds its last popped value between reads.
- Reset mid-operation: all state clears immediately and asynchronously. Frames already buffered are lost. A frame_valid high across reset release is not written.

Test Plan:
- Reset with frame_valid=1 held, then release -> no write; count=0, empty=1, overflow=0.
- frame=0x0A5 with frame_valid high for 5 cycles -> exactly one write. Then rd_en one cycle -> next cycle rd_valid=1, rd_data=0x0A5, count returns to 0, empty=1.
- Write 16 frames 0x100..0x10F -> full=1, count=16. A 17th frame 0x1FF -> dropped, overflow=1. Read 16 -> data 0x100..0x10F in order, 0x1FF never appears.
- While full, rd_en coincides with the rising edge of frame_valid for 0x055 -> count stays 16, overflow stays 0. 0x055 is read out last.
- rd_en on an empty FIFO in the same cycle as a write of 0x033 -> rd_valid=0, count=1. The next rd_en returns 0x033.
- Pointer wrap: 40 interleaved write/read pairs with incrementing data -> every read matches in order and count never exceeds 1.
- overflow set, then clr_overflow in the same cycle as a new overflow -> overflow remains 1. A later clr_overflow alone -> overflow=0.
